muldiv_seq: RTL and testbench

Iterative RV32M multiply/divide sequencer for the execute stage. It accepts one M-extension operation at a time, using forwarded operands from EX. It runs a shared 32-step shift-add / restoring shift-subtract engine and holds the front of the pipeline through a stall output until the result is ready. The result goes back to the EX result mux, so it enters the EX/MEM register on the cycle `done` is high.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/muldiv_step.sv | 37 +++
 rtl/muldiv_seq.sv | 136 +++++++++++++
 tb/tb_muldiv_seq.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the M-extension sequencer: width, funct3 encodings, FSM states.
package riscv_pkg;
  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_t;

  typedef enum logic {
    CLS_MUL = 1'b0,
    CLS_DIV = 1'b1
  } op_class_t;
endpackage

// File: rtl/muldiv_step.sv
// One shift-add (multiply) or restoring shift-subtract (divide) iteration.
// Division datapath exists only when MULDIV_DIV_EN is defined.
module muldiv_step
  import riscv_pkg::*;
(
  input  op_class_t       cls,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] opr,
  input  logic [XLEN-1:0] opb,
  output logic [XLEN-1:0] acc_next,
  output logic [XLEN-1:0] opr_next,
  output logic            q_bit
);
  logic [XLEN:0] sum;
`ifdef MULDIV_DIV_EN
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
`endif

  always_comb begin
    // {acc,opr} is the 64-bit partial product; it shifts right as multiplier bits are consumed
    sum      = {1'b0, acc} + (((cls == CLS_MUL) && opr[0]) ? {1'b0, opb} : '0);
    acc_next = sum[XLEN:1];
    opr_next = {sum[0], opr[XLEN-1:1]};
    q_bit    = 1'b0;
`ifdef MULDIV_DIV_EN
    shifted  = {acc, opr[XLEN-1]};
    diff     = shifted - {1'b0, opb};
    if (cls == CLS_DIV) begin
      // diff[XLEN] is the borrow: set means the divisor did not fit
      q_bit    = ~diff[XLEN];
      acc_next = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      opr_next = {opr[XLEN-2:0], 1'b0};
    end
`endif
  end
endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for EX; stalls the front end until done.
// Define MULDIV_DIV_EN for division; otherwise funct3 1xx completes at once with result 0.
module muldiv_seq
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            startE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic            flushE,
  output logic            stallE,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output md_state_t       state_dbg
);
  md_state_t       state;
  logic [4:0]      count;
  logic [2:0]      op;
  logic            neg_q;
  logic [XLEN-1:0] acc, mq, mag_b;
  logic [XLEN-1:0] acc_n, mq_n, opr_n;
  logic            q_bit;
`ifdef MULDIV_DIV_EN
  logic            neg_r;
`endif

  logic            sa, sb, start_fast;
  logic [XLEN-1:0] mag_a_in, mag_b_in, start_val, final_val;
  logic [2*XLEN-1:0] prod;

  muldiv_step u_step (
    .cls      (op[2] ? CLS_DIV : CLS_MUL),
    .acc      (acc),
    .opr      (mq),
    .opb      (mag_b),
    .acc_next (acc_n),
    .opr_next (opr_n),
    .q_bit    (q_bit)
  );
  assign mq_n = opr_n | {{(XLEN-1){1'b0}}, q_bit};

  always_comb begin
    sa = opA[XLEN-1] & (funct3E[2] ? ~funct3E[0] : (funct3E != F3_MULHU));
    sb = opB[XLEN-1] & (funct3E[2] ? ~funct3E[0] : ~funct3E[1]);
    mag_a_in = sa ? -opA : opA;
    mag_b_in = sb ? -opB : opB;
`ifdef MULDIV_DIV_EN
    start_fast = 1'b0;
    start_val  = '0;
    if (funct3E[2] && (opB == '0)) begin
      start_fast = 1'b1;
      start_val  = funct3E[1] ? opA : '1;
    end else if (funct3E[2] && !funct3E[0] &&
                 (opA == {1'b1, {(XLEN-1){1'b0}}}) && (opB == '1)) begin
      start_fast = 1'b1;
      start_val  = funct3E[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
`else
    start_fast = funct3E[2];
    start_val  = '0;
`endif
  end

  // Sign correction uses the values produced by the final iteration.
  always_comb begin
    prod = {acc_n, mq_n};
    if (neg_q) prod = -prod;
    final_val = (op == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
    if (op[2]) final_val = op[1] ? (neg_r ? -acc_n : acc_n) : (neg_q ? -mq_n : mq_n);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      op     <= F3_MUL;
      neg_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_r  <= 1'b0;
`endif
      acc    <= '0;
      mq     <= '0;
      mag_b  <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      if (flushE) begin
        state <= IDLE;
        count <= '0;
      end else begin
        case (state)
          IDLE: if (startE) begin
            op    <= funct3E;
            neg_q <= sa ^ sb;
`ifdef MULDIV_DIV_EN
            neg_r <= sa;
`endif
            acc   <= '0;
            mq    <= mag_a_in;
            mag_b <= mag_b_in;
            count <= '0;
            if (start_fast) begin
              result <= start_val;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              state  <= CALC;
            end
          end
          CALC: begin
            acc   <= acc_n;
            mq    <= mq_n;
            count <= count + 5'd1;
            if (count == 5'd31) begin
              result <= final_val;
              done   <= 1'b1;
              state  <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign stallE    = startE & ~done & ~flushE;
  assign busy      = (state != IDLE);
  assign state_dbg = state;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq; divide expectations follow whether MULDIV_DIV_EN is defined.
`timescale 1ns/1ps
module tb_muldiv_seq;
  import riscv_pkg::*;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        startE = 1'b0;
  logic        flushE = 1'b0;
  logic [2:0]  funct3E = 3'b000;
  logic [31:0] opA = '0;
  logic [31:0] opB = '0;
  logic        stallE, busy, done;
  logic [31:0] result;
  md_state_t   state_dbg;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_result = '0;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .startE    (startE),
    .funct3E   (funct3E),
    .opA       (opA),
    .opB       (opB),
    .flushE    (flushE),
    .stallE    (stallE),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .state_dbg (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts at posedge+1 of T0 and returns at posedge+1 of the cycle after DONE with startE low.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_v, input int lat);
    int          cyc;
    bit          got;
    logic [31:0] e;
    exp_q.push_back(exp_v);
    last_result = exp_v;
    startE = 1'b1; funct3E = f3; opA = a; opB = b;
    cyc = 0; got = 1'b0;
    while (!got && cyc <= 40) begin
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
      else begin
        check({tag, "_stall"}, {31'b0, stallE}, 32'd1);
        tick();
        cyc++;
        if (cyc == 12) opA = ~a;
      end
    end
    check({tag, "_done_seen"}, {31'b0, got}, 32'd1);
    check({tag, "_latency"}, cyc, lat);
    e = exp_q.pop_front();
    check({tag, "_result"}, result, e);
    check({tag, "_stall_at_done"}, {31'b0, stallE}, 32'd0);
    tick();
    startE = 1'b0; opA = '0; opB = '0;
    #1;
    check({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
    check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_state", {30'b0, state_dbg}, {30'b0, IDLE});
    check("rst_stall_lo", {31'b0, stallE}, 32'd0);
    startE = 1'b1;
    #1;
    check("rst_stall_hi", {31'b0, stallE}, 32'd1);
    startE = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Multiplies
    run_op("mul", F3_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("mulhu", F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mulh", F3_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op("mulhsu", F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);

    // Divides and special cases
    run_op("div", F3_DIV, 32'hFFFFFFF9, 32'd2, DIV_EN ? 32'hFFFFFFFD : 32'd0, DIV_EN ? 33 : 1);
    run_op("rem", F3_REM, 32'hFFFFFFF9, 32'd2, DIV_EN ? 32'hFFFFFFFF : 32'd0, DIV_EN ? 33 : 1);
    run_op("divu_z", F3_DIVU, 32'd5, 32'd0, DIV_EN ? 32'hFFFFFFFF : 32'd0, 1);
    run_op("remu_z", F3_REMU, 32'd5, 32'd0, DIV_EN ? 32'd5 : 32'd0, 1);
    run_op("div_ovf", F3_DIV, 32'h80000000, 32'hFFFFFFFF, DIV_EN ? 32'h80000000 : 32'd0, 1);

    // Flush at T10 of a MUL
    startE = 1'b1; funct3E = F3_MUL; opA = 32'd9; opB = 32'd9;
    repeat (10) tick();
    flushE = 1'b1;
    #1;
    check("flush_stall", {31'b0, stallE}, 32'd0);
    tick();
    flushE = 1'b0; startE = 1'b0;
    #1;
    check("flush_state", {30'b0, state_dbg}, {30'b0, IDLE});
    check("flush_busy", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("flush_no_done", {31'b0, done}, 32'd0);
      check("flush_result_kept", result, last_result);
      tick();
    end
    run_op("mul_after_flush", F3_MUL, 32'd3, 32'd4, 32'd12, 33);

    // Asynchronous reset at T15 of a DIV
    startE = 1'b1; funct3E = F3_DIV; opA = 32'd1000; opB = 32'd3;
    repeat (15) tick();
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_state", {30'b0, state_dbg}, {30'b0, IDLE});
    check("arst_stall", {31'b0, stallE}, 32'd1);
    startE = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    run_op("divu_after_rst", F3_DIVU, 32'd100, 32'd7, DIV_EN ? 32'd14 : 32'd0, DIV_EN ? 33 : 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
